// File: rtl/owm_pkg.sv
// Shared types and constants for the 1-wire bit engine.
package owm_pkg;

  localparam int OWM_TW_DEFAULT = 16;

  localparam int CMD_RST = 0;
  localparam int CMD_WR  = 1;
  localparam int CMD_RD  = 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RST_LOW,
    ST_RST_HIGH,
    ST_WR_LOW,
    ST_WR_HIGH,
    ST_RD_LOW,
    ST_RD_HIGH,
    ST_REC
  } owm_state_t;

endpackage

// File: rtl/owm_prescaler.sv
// Tick generator: one-clock tick when the count reaches prcl_i, i.e. every prcl_i+1 clocks.
// restart_i forces the count back to 0 so the first tick lands prcl_i+1 clocks later.
module owm_prescaler
  import owm_pkg::*;
#(
  parameter int TW = OWM_TW_DEFAULT
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          restart_i,
  input  logic [TW-1:0] prcl_i,
  output logic          tick_o
);

  logic [TW-1:0] r_cnt;

  assign tick_o = (r_cnt == prcl_i);

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_cnt <= '0;
    end else if (restart_i || tick_o) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + TW'(1);
    end
  end

endmodule

// File: rtl/owm_bit_engine.sv
// 1-wire reset/write/read slot generator driving an open-drain bus, one command at a time.
// OWM_OW_SYNC_EN adds a 2-flop synchronizer on ow_i; drive timing is unaffected.
module owm_bit_engine
  import owm_pkg::*;
#(
  parameter int OWM_TW = OWM_TW_DEFAULT
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic [2:0]        cmd_i,
  input  logic              start_i,
  input  logic              wrdat_i,
  output logic              ready_o,
  output logic              presence_o,
  output logic              rddat_o,
  input  logic [OWM_TW-1:0] clk_prcl_i,
  input  logic [OWM_TW-1:0] t_reset_l_i,
  input  logic [OWM_TW-1:0] t_reset_h_i,
  input  logic [OWM_TW-1:0] t_reset_pd_i,
  input  logic [OWM_TW-1:0] t_write_slot_i,
  input  logic [OWM_TW-1:0] t_write_l_i,
  input  logic [OWM_TW-1:0] t_write_rec_i,
  input  logic [OWM_TW-1:0] t_read_slot_i,
  input  logic [OWM_TW-1:0] t_read_l_i,
  input  logic [OWM_TW-1:0] t_read_read_i,
  input  logic [OWM_TW-1:0] t_read_rec_i,
  input  logic              ow_i,
  output logic              ow_drive_o
);

  owm_state_t        r_state;
  logic              r_ready, r_presence, r_rddat, r_drive, r_skip_b;
  logic [OWM_TW-1:0] r_prcl, r_cnt, r_len_a, r_len_b, r_len_c, r_smp;

  logic              w_tick, w_start, w_last, w_smp_hit, w_ow, w_skip_b;
  owm_state_t        w_first;
  logic [OWM_TW-1:0] w_len, w_len_a, w_len_b, w_len_c, w_smp;
  logic [OWM_TW:0]   w_idx, w_diff_b, w_diff_s;

  function automatic logic [OWM_TW-1:0] eff(input logic [OWM_TW-1:0] n);
    return (n == '0) ? OWM_TW'(1) : n;
  endfunction

`ifdef OWM_OW_SYNC_EN
  logic [1:0] r_ow_sync;
  always_ff @(posedge clk_i) begin
    if (!rst_ni) r_ow_sync <= 2'b11;
    else         r_ow_sync <= {r_ow_sync[0], ow_i};
  end
  assign w_ow = r_ow_sync[1];
`else
  assign w_ow = ow_i;
`endif

  owm_prescaler #(.TW(OWM_TW)) u_prescaler (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .restart_i (w_start),
    .prcl_i    (r_prcl),
    .tick_o    (w_tick)
  );

  assign w_start = start_i & r_ready & (|cmd_i);

  // Phase lengths (a=low, b=release, c=recovery) and the sample index, counted in
  // ticks of the release phase, are resolved once at acceptance.
  always_comb begin
    w_first  = ST_IDLE;
    w_len_a  = OWM_TW'(1);
    w_len_b  = OWM_TW'(1);
    w_len_c  = OWM_TW'(1);
    w_smp    = OWM_TW'(1);
    w_skip_b = 1'b0;
    w_diff_b = '0;
    w_diff_s = '0;
    if (cmd_i[CMD_RST]) begin
      w_first = ST_RST_LOW;
      w_len_a = eff(t_reset_l_i);
      w_len_b = eff(t_reset_h_i);
      w_smp   = eff(t_reset_pd_i);
    end else if (cmd_i[CMD_WR]) begin
      w_first  = ST_WR_LOW;
      w_len_a  = wrdat_i ? eff(t_write_l_i) : eff(t_write_slot_i);
      w_diff_b = {1'b0, eff(t_write_slot_i)} - {1'b0, w_len_a};
      w_skip_b = (w_diff_b == '0) || w_diff_b[OWM_TW];
      w_len_b  = w_diff_b[OWM_TW-1:0];
      w_len_c  = eff(t_write_rec_i);
    end else begin
      w_first  = ST_RD_LOW;
      w_len_a  = eff(t_read_l_i);
      w_diff_b = {1'b0, eff(t_read_slot_i)} - {1'b0, w_len_a};
      w_len_b  = ((w_diff_b == '0) || w_diff_b[OWM_TW]) ? OWM_TW'(1) : w_diff_b[OWM_TW-1:0];
      w_diff_s = {1'b0, t_read_read_i} - {1'b0, w_len_a};
      w_smp    = ((w_diff_s == '0) || w_diff_s[OWM_TW]) ? OWM_TW'(1) : w_diff_s[OWM_TW-1:0];
      w_len_c  = eff(t_read_rec_i);
    end
  end

  always_comb begin
    case (r_state)
      ST_RST_LOW, ST_WR_LOW, ST_RD_LOW: w_len = r_len_a;
      ST_REC:                           w_len = r_len_c;
      default:                          w_len = r_len_b;
    endcase
  end

  assign w_idx     = {1'b0, r_cnt} + (OWM_TW+1)'(1);
  assign w_last    = (w_idx >= {1'b0, w_len});
  // A sample index beyond the release phase collapses onto its last tick.
  assign w_smp_hit = (w_idx == {1'b0, r_smp}) || (w_last && (w_idx < {1'b0, r_smp}));

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_state    <= ST_IDLE;
      r_ready    <= 1'b1;
      r_presence <= 1'b0;
      r_rddat    <= 1'b0;
      r_drive    <= 1'b0;
      r_cnt      <= '0;
      r_prcl     <= '0;
      r_len_a    <= '0;
      r_len_b    <= '0;
      r_len_c    <= '0;
      r_smp      <= '0;
      r_skip_b   <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_start) begin
            r_state  <= w_first;
            r_ready  <= 1'b0;
            r_drive  <= 1'b1;
            r_cnt    <= '0;
            r_prcl   <= clk_prcl_i;
            r_len_a  <= w_len_a;
            r_len_b  <= w_len_b;
            r_len_c  <= w_len_c;
            r_smp    <= w_smp;
            r_skip_b <= w_skip_b;
          end
        end
        default: begin
          if (w_tick) begin
            r_cnt <= w_last ? '0 : w_idx[OWM_TW-1:0];
            if (w_smp_hit && (r_state == ST_RST_HIGH)) r_presence <= ~w_ow;
            if (w_smp_hit && (r_state == ST_RD_HIGH))  r_rddat    <= w_ow;
            if (w_last) begin
              case (r_state)
                ST_RST_LOW: begin
                  r_state <= ST_RST_HIGH;
                  r_drive <= 1'b0;
                end
                ST_WR_LOW: begin
                  r_state <= r_skip_b ? ST_REC : ST_WR_HIGH;
                  r_drive <= 1'b0;
                end
                ST_RD_LOW: begin
                  r_state <= ST_RD_HIGH;
                  r_drive <= 1'b0;
                end
                ST_WR_HIGH, ST_RD_HIGH: r_state <= ST_REC;
                default: begin
                  r_state <= ST_IDLE;
                  r_ready <= 1'b1;
                end
              endcase
            end
          end
        end
      endcase
    end
  end

  assign ready_o    = r_ready;
  assign presence_o = r_presence;
  assign rddat_o    = r_rddat;
  assign ow_drive_o = r_drive;

endmodule

// File: tb/tb_owm_bit_engine.sv
// Directed and randomized checks of owm_bit_engine against a slot-arithmetic reference model.
module tb_owm_bit_engine;

  localparam int TW = 16;
`ifdef OWM_OW_SYNC_EN
  localparam int SD = 2;
`else
  localparam int SD = 0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n, start, wrdat, ow;
  logic [2:0]    cmd;
  logic [TW-1:0] prcl, rl, rh, pd, ws, wl, wrec, rs, rlow, rr, rrec;
  logic          ready, presence, rddat, drive;

  int   checks = 0;
  int   errors = 0;
  logic m_pres = 1'b0;
  logic m_rd   = 1'b0;

  owm_bit_engine dut (
    .clk_i(clk), .rst_ni(rst_n), .cmd_i(cmd), .start_i(start), .wrdat_i(wrdat),
    .ready_o(ready), .presence_o(presence), .rddat_o(rddat),
    .clk_prcl_i(prcl), .t_reset_l_i(rl), .t_reset_h_i(rh), .t_reset_pd_i(pd),
    .t_write_slot_i(ws), .t_write_l_i(wl), .t_write_rec_i(wrec),
    .t_read_slot_i(rs), .t_read_l_i(rlow), .t_read_read_i(rr), .t_read_rec_i(rrec),
    .ow_i(ow), .ow_drive_o(drive)
  );

  function automatic int e(input logic [TW-1:0] x);
    return (x == '0) ? 1 : int'(x);
  endfunction

  function automatic logic owl(input int k, input int s, input int en);
    return (k >= s && k <= en) ? 1'b0 : 1'b1;
  endfunction

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // kind: 0 reset, 1 write, 2 read. Offsets count cycles from the acceptance cycle C.
  task automatic exec(input int kind, input logic wb, input logic [2:0] c,
                      input int lo_s, input int lo_e, input int poke, input bit b2b);
    int p, low, high, slot, smp, dlen, busy, soff, dbad, rbad;
    p = int'(prcl) + 1;
    soff = 0;
    if (kind == 0) begin
      low  = e(rl);
      high = e(rh);
      busy = (low + high) * p;
      soff = (low + ((e(pd) < high) ? e(pd) : high)) * p;
    end else if (kind == 1) begin
      slot = e(ws);
      low  = wb ? e(wl) : slot;
      high = (slot > low) ? slot - low : 0;
      busy = (low + high + e(wrec)) * p;
    end else begin
      low  = e(rlow);
      slot = e(rs);
      high = (slot > low) ? slot - low : 1;
      busy = (low + high + e(rrec)) * p;
      smp  = (int'(rr) > low + 1) ? int'(rr) : low + 1;
      if (smp > low + high) smp = low + high;
      soff = smp * p;
    end
    dlen = low * p;
    if (!b2b) @(negedge clk);
    cmd = c; wrdat = wb; start = 1'b1; ow = owl(0, lo_s, lo_e);
    dbad = 0; rbad = 0;
    for (int k = 1; k <= busy + 1; k++) begin
      @(negedge clk);
      start = (k == poke && k <= busy);
      cmd   = start ? 3'b001 : 3'b000;
      wrdat = 1'($urandom);
      ow    = owl(k, lo_s, lo_e);
      if (drive !== (k <= dlen)) dbad++;
      if (ready !== (k > busy))  rbad++;
    end
    if (kind == 0) m_pres = ~owl(soff - SD, lo_s, lo_e);
    if (kind == 2) m_rd   = owl(soff - SD, lo_s, lo_e);
    check($sformatf("drive_wave_k%0d", kind), dbad, 0);
    check($sformatf("ready_timing_k%0d", kind), rbad, 0);
    check("presence", presence, m_pres);
    check("rddat", rddat, m_rd);
  endtask

  initial begin
    int bad, kind, lo_s, poke;
    logic [2:0] c;
    rst_n = 1'b0; start = 1'b0; cmd = '0; wrdat = 1'b0; ow = 1'b1;
    prcl = '0; rl = '0; rh = '0; pd = '0; ws = '0; wl = '0; wrec = '0;
    rs = '0; rlow = '0; rr = '0; rrec = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("reset_ready", ready, 1);
    check("reset_drive", drive, 0);
    check("reset_presence", presence, 0);
    check("reset_rddat", rddat, 0);

    // Reset slot with a presence pulse spanning the sample tick.
    prcl = 16'd4; rl = 16'd10; rh = 16'd10; pd = 16'd7;
    exec(0, 1'b0, 3'b001, 75, 95, 0, 1'b0);

    // Write 1 then write 0, back to back.
    prcl = 16'd0; ws = 16'd60; wl = 16'd6; wrec = 16'd2;
    exec(1, 1'b1, 3'b010, 1, 0, 0, 1'b0);
    exec(1, 1'b0, 3'b010, 1, 0, 0, 1'b1);

    // Read with slave holding the bus low, then with the bus left high.
    rlow = 16'd2; rr = 16'd13; rs = 16'd60; rrec = 16'd2;
    exec(2, 1'b0, 3'b100, 1, 30, 0, 1'b0);
    exec(2, 1'b0, 3'b100, 1, 0, 0, 1'b1);

    // Synchronous reset in the middle of the reset-low phase.
    prcl = 16'd1; rl = 16'd20; rh = 16'd5; pd = 16'd3;
    @(negedge clk);
    cmd = 3'b001; start = 1'b1;
    repeat (10) begin
      @(negedge clk);
      start = 1'b0; cmd = 3'b000;
    end
    rst_n = 1'b0;
    @(negedge clk);
    m_pres = 1'b0; m_rd = 1'b0;
    check("midrst_drive", drive, 0);
    check("midrst_ready", ready, 1);
    check("midrst_presence", presence, 0);
    check("midrst_rddat", rddat, 0);
    rst_n = 1'b1;

    // All command bits set: only the reset slot runs.
    exec(0, 1'b1, 3'b111, 12, 30, 0, 1'b0);

    // Start with no command bits is ignored.
    @(negedge clk);
    cmd = 3'b000; start = 1'b1;
    bad = 0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      start = 1'b0;
      if (drive !== 1'b0 || ready !== 1'b1) bad++;
    end
    check("nocmd_idle", bad, 0);

    // Stray start while busy must not disturb the waveform.
    prcl = 16'd0;
    exec(1, 1'b1, 3'b010, 1, 0, 5, 1'b0);
    exec(2, 1'b0, 3'b100, 1, 40, 20, 1'b0);

    for (int t = 0; t < 30; t++) begin
      prcl = TW'($urandom_range(0, 3));
      rl = TW'($urandom_range(0, 12)); rh = TW'($urandom_range(0, 12));
      pd = TW'($urandom_range(0, 14));
      ws = TW'($urandom_range(0, 12)); wl = TW'($urandom_range(0, 12));
      wrec = TW'($urandom_range(0, 4));
      rs = TW'($urandom_range(0, 12)); rlow = TW'($urandom_range(0, 6));
      rr = TW'($urandom_range(0, 14)); rrec = TW'($urandom_range(0, 4));
      kind = $urandom_range(0, 2);
      c = (kind == 0) ? {2'($urandom), 1'b1} : (kind == 1) ? {1'($urandom), 2'b10} : 3'b100;
      lo_s = $urandom_range(0, 40);
      poke = ($urandom_range(0, 1) == 1) ? $urandom_range(1, 10) : 0;
      exec(kind, 1'($urandom), c, lo_s, lo_s + $urandom_range(0, 30), poke,
           (t > 0) && ($urandom_range(0, 1) == 1));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
